ras_stack: RTL and testbench

Return-address stack for the fetch stage. It records the return address (PC+1) on every `jal` and supplies the predicted target for `jr $31` before the register file is read. It sits beside the program counter register as the consumer/producer pair for return targets: the PC side pushes link addresses, and `ras_stack` hands them back. The stack is a circular buffer of `DEPTH` entries with overwrite-oldest on overflow, defined underflow behaviour, and a flush for pipeline redirects.

---
 rtl/ras_stack.sv | 112 +++++++++++
 tb/tb_ras_stack.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ras_stack.sv
// ============================================================================
// Module   : ras_stack
// Purpose  : Circular return-address stack for fetch-stage `jr $31` prediction.
//            Overwrites the oldest entry on overflow; flush discards all.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ras_stack #(
  parameter int DEPTH = 8,
  parameter int AW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [AW-1:0]              push_addr,
  input  logic                       pop,
  input  logic                       flush,
  output logic [AW-1:0]              top_addr,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int                PTR_W      = $clog2(DEPTH);
  localparam int                CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0]  c_full_cnt = CNT_W'(DEPTH);

  logic [AW-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0] r_tp;
  logic [CNT_W-1:0] r_cnt;
  logic             r_overflow;
  logic             r_underflow;

  logic [PTR_W-1:0] w_tp_dec;
  logic [PTR_W-1:0] w_tp_inc;
  logic             w_is_empty;
  logic             w_is_full;
  logic             w_wr_en;
  logic [PTR_W-1:0] w_wr_idx;

  assign w_tp_dec   = r_tp - 1'b1;
  assign w_tp_inc   = r_tp + 1'b1;
  assign w_is_empty = (r_cnt == '0);
  assign w_is_full  = (r_cnt == c_full_cnt);

  // A push paired with a pop replaces the top entry in place, unless the
  // stack is empty, in which case it behaves as a plain push.
  assign w_wr_en  = !rst && !flush && push;
  assign w_wr_idx = (pop && !w_is_empty) ? w_tp_dec : r_tp;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= push_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tp        <= '0;
      r_cnt       <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_tp        <= '0;
      r_cnt       <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      case ({push, pop})
        2'b10: begin
          r_tp <= w_tp_inc;
          if (w_is_full) begin
            r_overflow <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        2'b01: begin
          if (w_is_empty) begin
            r_underflow <= 1'b1;
          end else begin
            r_tp  <= w_tp_dec;
            r_cnt <= r_cnt - 1'b1;
          end
        end
        2'b11: begin
          if (w_is_empty) begin
            r_tp  <= w_tp_inc;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign top_addr  = w_is_empty ? '0 : r_mem[w_tp_dec];
  assign empty     = w_is_empty;
  assign full      = w_is_full;
  assign count     = r_cnt;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_ras_stack.sv
// ============================================================================
// Module   : tb_ras_stack
// Purpose  : Directed and random stimulus for ras_stack against a queue model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ras_stack;

  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0;
  logic [AW-1:0] push_addr = '0;
  logic          pop = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] top_addr;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int errors = 0;

  // Reference model: youngest entry at the back of the queue.
  logic [AW-1:0] q[$];
  logic          m_ov = 1'b0;
  logic          m_un = 1'b0;

  ras_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (push_addr),
    .pop       (pop),
    .flush     (flush),
    .top_addr  (top_addr),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic f, input logic pu,
                              input logic po, input logic [AW-1:0] a);
    if (r || f) begin
      q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      m_ov = 1'b0;
      m_un = 1'b0;
      if (pu && po) begin
        if (q.size() == 0) q.push_back(a);
        else q[q.size()-1] = a;
      end else if (pu) begin
        if (q.size() == DEPTH) begin
          void'(q.pop_front());
          m_ov = 1'b1;
        end
        q.push_back(a);
      end else if (po) begin
        if (q.size() == 0) m_un = 1'b1;
        else void'(q.pop_back());
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [AW-1:0] exp_top;
    exp_top = (q.size() == 0) ? '0 : q[q.size()-1];
    check({tag, ".top"},   top_addr,          exp_top);
    check({tag, ".count"}, AW'(count),        AW'(q.size()));
    check({tag, ".empty"}, AW'(empty),        AW'(q.size() == 0));
    check({tag, ".full"},  AW'(full),         AW'(q.size() == DEPTH));
    check({tag, ".ovf"},   AW'(overflow),     AW'(m_ov));
    check({tag, ".unf"},   AW'(underflow),    AW'(m_un));
  endtask

  // Apply one cycle of inputs, advance the clock, then compare.
  task automatic step(input string tag, input logic r, input logic f, input logic pu,
                      input logic po, input logic [AW-1:0] a);
    rst = r; flush = f; push = pu; pop = po; push_addr = a;
    @(posedge clk);
    model_update(r, f, pu, po, a);
    #1;
    check_all(tag);
  endtask

  initial begin
    // Reset held with a push pending
    step("rst0", 1, 0, 1, 0, 32'h40);
    step("rst1", 1, 0, 1, 0, 32'h40);

    // LIFO order
    step("lifo_p1", 0, 0, 1, 0, 32'h10);
    step("lifo_p2", 0, 0, 1, 0, 32'h20);
    step("lifo_p3", 0, 0, 1, 0, 32'h30);
    for (int i = 0; i < 3; i++) step("lifo_pop", 0, 0, 0, 1, '0);

    // Overflow wrap and draining past empty
    for (int i = 1; i <= 9; i++) step("ovf_push", 0, 0, 1, 0, AW'(i));
    step("ovf_idle", 0, 0, 0, 0, '0);
    for (int i = 0; i < 9; i++) step("ovf_pop", 0, 0, 0, 1, '0);

    // Underflow on empty
    step("unf_pop", 0, 0, 0, 1, '0);
    step("unf_idle", 0, 0, 0, 0, '0);

    // Simultaneous push and pop
    step("pp_p1", 0, 0, 1, 0, 32'h10);
    step("pp_p2", 0, 0, 1, 0, 32'h20);
    step("pp_both", 0, 0, 1, 1, 32'h55);
    step("pp_pop", 0, 0, 0, 1, '0);
    step("pp_pop2", 0, 0, 0, 1, '0);
    step("pp_empty_both", 0, 0, 1, 1, 32'h7);
    step("pp_pop3", 0, 0, 0, 1, '0);

    // Flush priority, then reset over flush
    step("fl_p1", 0, 0, 1, 0, 32'h1);
    step("fl_p2", 0, 0, 1, 0, 32'h2);
    step("fl_p3", 0, 0, 1, 0, 32'h3);
    step("fl_flush", 0, 1, 1, 0, 32'h99);
    step("fl_push", 0, 0, 1, 0, 32'hA);
    step("fl_rst", 1, 1, 0, 0, '0);

    // Random operations with rare flush/reset
    for (int i = 0; i < 400; i++) begin
      logic r, f, pu, po;
      r  = ($urandom_range(0, 99) < 2);
      f  = ($urandom_range(0, 99) < 3);
      pu = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 45);
      step("rand", r, f, pu, po, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
